hyper_tx_arbiter: RTL

- Round-robin, burst-locked arbiter that shares the single write port of the HyperBus CDC FIFO (source side) between NB_CH requesters (TX channels, command path).
- Sits entirely in the source clock domain, directly in front of the FIFO push interface.
- Tags each beat with its channel ID so the destination domain can demultiplex.

---
 rtl/hyper_arb_pkg.sv | 22 ++
 rtl/hyper_rr_select.sv | 41 ++++
 rtl/hyper_tx_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/hyper_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hyper_arb_pkg: shared types and helpers for the HyperBus TX arbiter  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package hyper_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // FIFO word is {id, last, data}; offsets are relative to the top of data
  localparam int unsigned c_last_ofs = 0;
  localparam int unsigned c_id_ofs   = 1;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nb_ch);
    return (ptr + 32'd1 >= nb_ch) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hyper_rr_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hyper_rr_select: first requester at or above rr pointer, wrapping    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hyper_rr_select #(
  parameter int unsigned NB_CH = 4,
  parameter int unsigned ID_W  = $clog2(NB_CH)
) (
  input  logic [NB_CH-1:0] i_req,
  input  logic [ID_W-1:0]  i_rr_ptr,
  output logic [ID_W-1:0]  o_winner,
  output logic             o_any_req
);

  logic [ID_W:0]   w_cand;
  logic [ID_W-1:0] w_idx;
  logic            w_found;

  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_cand   = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < NB_CH; k++) begin
      w_cand = {1'b0, i_rr_ptr} + (ID_W+1)'(k);
      if (w_cand >= (ID_W+1)'(NB_CH)) begin
        w_cand = w_cand - (ID_W+1)'(NB_CH);
      end
      w_idx = w_cand[ID_W-1:0];
      if (!w_found && i_req[w_idx]) begin
        w_found  = 1'b1;
        o_winner = w_idx;
      end
    end
  end

  assign o_any_req = |i_req;

endmodule
`default_nettype wire

// File: rtl/hyper_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hyper_tx_arbiter: burst-locked round-robin arbiter onto the CDC FIFO |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hyper_tx_arbiter
  import hyper_arb_pkg::*;
#(
  parameter int unsigned NB_CH     = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                          src_clk_i,
  input  logic                          src_rst_ni,
  input  logic [NB_CH-1:0]              ch_valid_i,
  input  logic [NB_CH-1:0]              ch_last_i,
  input  logic [NB_CH-1:0][DATA_W-1:0]  ch_data_i,
  output logic [NB_CH-1:0]              ch_ready_o,
  output logic                          fifo_valid_o,
  input  logic                          fifo_ready_i,
  output logic [$clog2(NB_CH)+DATA_W:0] fifo_data_o,
  output logic                          busy_o,
  output logic [$clog2(NB_CH)-1:0]      gnt_id_o
);

  localparam int unsigned ID_W    = $clog2(NB_CH);
  localparam int unsigned c_cnt_w = $clog2(MAX_BURST + 1);

  arb_state_e           r_state, w_state_nxt;
  logic [ID_W-1:0]      r_gnt, w_gnt_nxt;
  logic [ID_W-1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic [c_cnt_w-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic [ID_W-1:0]      w_winner;
  logic                 w_any_req;
  logic                 w_hs;

  hyper_rr_select #(
    .NB_CH (NB_CH),
    .ID_W  (ID_W)
  ) u_rr_select (
    .i_req     (ch_valid_i),
    .i_rr_ptr  (r_rr_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
    if (!src_rst_ni) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    fifo_valid_o   = 1'b0;
    ch_ready_o     = '0;
    fifo_data_o    = '0;
    w_hs           = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_gnt_nxt      = w_winner;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = BURST;
        end
      end
      BURST: begin
        // Payload is forwarded straight through; requesters hold it until ready
        fifo_valid_o                              = ch_valid_i[r_gnt];
        ch_ready_o[r_gnt]                         = fifo_ready_i;
        fifo_data_o[DATA_W-1:0]                   = ch_data_i[r_gnt];
        fifo_data_o[DATA_W+c_last_ofs]            = ch_last_i[r_gnt];
        fifo_data_o[DATA_W+c_id_ofs +: ID_W]      = r_gnt;
        w_hs = ch_valid_i[r_gnt] && fifo_ready_i;
        if (w_hs) begin
          w_beat_cnt_nxt = r_beat_cnt + c_cnt_w'(1);
          if (ch_last_i[r_gnt] || (r_beat_cnt == c_cnt_w'(MAX_BURST - 1))) begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = ID_W'(rr_next(32'(r_gnt), NB_CH));
          end
        end
      end
    endcase
  end

  assign busy_o   = (r_state == BURST);
  assign gnt_id_o = r_gnt;

endmodule
`default_nettype wire
